// File: rtl/sram_bus_pkg.sv
// Shared definitions for the SRAM/UART bus controller: FSM encoding,
// access-size codes and the UART status register offset.
package sram_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [31:0] UART_STAT_OFS = 32'h0000_0004;

  function automatic logic is_uart_stat(input logic [31:0] addr);
    return |(addr & UART_STAT_OFS);
  endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Combinational lane logic: byte enables, write-lane replication and
// read-lane extraction with zero/sign extension.
module byte_lane_unit
  import sram_bus_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        sext_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rbus_i,
  output logic [3:0]  be_n_o,
  output logic [31:0] wlane_o,
  output logic [31:0] rext_o
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    rbyte = rbus_i[7:0];
    case (addr_lo_i)
      2'd1:    rbyte = rbus_i[15:8];
      2'd2:    rbyte = rbus_i[23:16];
      2'd3:    rbyte = rbus_i[31:24];
      default: rbyte = rbus_i[7:0];
    endcase
  end

  // addr_lo_i[0] is deliberately ignored for halfword accesses
  assign rhalf = addr_lo_i[1] ? rbus_i[31:16] : rbus_i[15:0];

  always_comb begin
    be_n_o  = 4'b0000;
    wlane_o = wdata_i;
    rext_o  = rbus_i;
    case (size_i)
      SZ_BYTE: begin
        be_n_o  = ~(4'b0001 << addr_lo_i);
        wlane_o = {4{wdata_i[7:0]}};
        rext_o  = {{24{sext_i & rbyte[7]}}, rbyte};
      end
      SZ_HALF: begin
        be_n_o  = addr_lo_i[1] ? 4'b0011 : 4'b1100;
        wlane_o = {2{wdata_i[15:0]}};
        rext_o  = {{16{sext_i & rhalf[15]}}, rhalf};
      end
      default: begin
        be_n_o  = 4'b0000;
        wlane_o = wdata_i;
        rext_o  = rbus_i;
      end
    endcase
  end

endmodule

// File: rtl/sram_bus_ctrl.sv
// CPU-to-SRAM bus controller with base/ext banks and optional UART decode.
// Define SRAM_BUS_UART_EN to enable UART address space handling.
module sram_bus_ctrl
  import sram_bus_pkg::*;
#(
  parameter int WAIT_CYC     = 1,
  parameter int RAM_AW       = 20,
  parameter int EXT_SEL_BIT  = 22,
  parameter int UART_SEL_BIT = 29
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic              sext,
  input  logic [1:0]        size,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ack,
  output logic              busy,
  inout  wire  [31:0]       base_ram_data,
  output logic [RAM_AW-1:0] base_ram_addr,
  output logic [3:0]        base_ram_be_n,
  output logic              base_ram_ce_n,
  output logic              base_ram_oe_n,
  output logic              base_ram_we_n,
  inout  wire  [31:0]       ext_ram_data,
  output logic [RAM_AW-1:0] ext_ram_addr,
  output logic [3:0]        ext_ram_be_n,
  output logic              ext_ram_ce_n,
  output logic              ext_ram_oe_n,
  output logic              ext_ram_we_n,
  output logic              uart_rdn,
  output logic              uart_wrn,
  input  logic              uart_dataready,
  input  logic              uart_tbre,
  input  logic              uart_tsre
);

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d;
  logic        sext_q, sext_d;

  logic        active, ext_sel, ram_sel, base_sel, ext_bank, rd_phase;
  logic        is_uart, uart_data, tx_ready;
  logic [31:0] uart_stat_word;
  logic        base_drv, uart_drv, ext_drv;
  logic [3:0]  lane_be_n;
  logic [31:0] lane_wdata, lane_rext, rd_bus, capture;
  logic        unused_bits;

  assign active   = (state_q != IDLE);
  assign ext_sel  = addr_q[EXT_SEL_BIT];
  assign rd_phase = (state_q == SETUP) || (state_q == ACCESS);

`ifdef SRAM_BUS_UART_EN
  assign is_uart        = addr_q[UART_SEL_BIT];
  assign uart_data      = is_uart && !is_uart_stat(addr_q);
  assign tx_ready       = uart_tbre && uart_tsre;
  assign uart_stat_word = {30'b0, uart_dataready, uart_tbre};
  assign uart_rdn       = !((state_q == ACCESS) && uart_data && !we_q);
  assign uart_wrn       = !((state_q == ACCESS) && uart_data && we_q);
`else
  logic unused_uart;
  assign unused_uart    = ^{uart_dataready, uart_tbre, uart_tsre};
  assign is_uart        = 1'b0;
  assign uart_data      = 1'b0;
  assign tx_ready       = 1'b1;
  assign uart_stat_word = 32'h0;
  assign uart_rdn       = 1'b1;
  assign uart_wrn       = 1'b1;
`endif

  assign unused_bits = ^{addr_q, wdata_q};

  byte_lane_unit u_lanes (
    .size_i   (size_q),
    .addr_lo_i(addr_q[1:0]),
    .sext_i   (sext_q),
    .wdata_i  (wdata_q),
    .rbus_i   (rd_bus),
    .be_n_o   (lane_be_n),
    .wlane_o  (lane_wdata),
    .rext_o   (lane_rext)
  );

  assign ram_sel  = active && !is_uart;
  assign base_sel = ram_sel && !ext_sel;
  assign ext_bank = ram_sel && ext_sel;

  assign base_ram_addr = addr_q[RAM_AW+1:2];
  assign ext_ram_addr  = addr_q[RAM_AW+1:2];
  assign base_ram_ce_n = !base_sel;
  assign ext_ram_ce_n  = !ext_bank;
  assign base_ram_oe_n = !(base_sel && !we_q && rd_phase);
  assign ext_ram_oe_n  = !(ext_bank && !we_q && rd_phase);
  assign base_ram_we_n = !(base_sel && we_q && (state_q == ACCESS));
  assign ext_ram_we_n  = !(ext_bank && we_q && (state_q == ACCESS));
  assign base_ram_be_n = base_sel ? lane_be_n : 4'hF;
  assign ext_ram_be_n  = ext_bank ? lane_be_n : 4'hF;

  // Only one bank (or the UART byte lane of base) can ever be driven
  assign base_drv = base_sel && we_q;
  assign uart_drv = active && uart_data && we_q;
  assign ext_drv  = ext_bank && we_q;

  assign base_ram_data[31:8] = base_drv ? lane_wdata[31:8] : 24'bz;
  assign base_ram_data[7:0]  = (base_drv || uart_drv) ? lane_wdata[7:0] : 8'bz;
  assign ext_ram_data        = ext_drv ? lane_wdata : 32'bz;

  assign rd_bus  = ext_sel ? ext_ram_data : base_ram_data;
  assign capture = !is_uart  ? lane_rext :
                   uart_data ? {24'b0, base_ram_data[7:0]} : uart_stat_word;

  assign rdata = rdata_q;
  assign ack   = (state_q == DONE);
  assign busy  = active;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    we_d    = we_q;
    sext_d  = sext_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = addr;
          wdata_d = wdata;
          size_d  = size;
          we_d    = we;
          sext_d  = sext;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (!(uart_data && we_q) || tx_ready) begin
          cnt_d   = WAIT_LD;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) rdata_d = capture;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      size_q  <= SZ_BYTE;
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      size_q  <= size_d;
      we_q    <= we_d;
      sext_q  <= sext_d;
    end
  end

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Directed bench for sram_bus_ctrl: SRAM bank models, word/half/byte access,
// reset abort and (with SRAM_BUS_UART_EN) UART space.
module tb_sram_bus_ctrl;
  import sram_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, we = 1'b0, sext = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic [31:0] rdata;
  logic        ack, busy;
  wire  [31:0] base_ram_data, ext_ram_data;
  logic [19:0] base_ram_addr, ext_ram_addr;
  logic [3:0]  base_ram_be_n, ext_ram_be_n;
  logic        base_ram_ce_n, base_ram_oe_n, base_ram_we_n;
  logic        ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n;
  logic        uart_rdn, uart_wrn;
  logic        uart_dataready = 1'b0, uart_tbre = 1'b1, uart_tsre = 1'b1;

  logic [31:0] base_rd_val = 32'h0;
  logic [31:0] ext_rd_val  = 32'h0;
  logic [7:0]  uart_rx_val = 8'h0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // SRAM and UART receive-register models drive the buses only when read-enabled
  assign base_ram_data[31:8] = !base_ram_oe_n ? base_rd_val[31:8] : 24'bz;
  assign base_ram_data[7:0]  = !base_ram_oe_n ? base_rd_val[7:0] :
                               (!uart_rdn ? uart_rx_val : 8'bz);
  assign ext_ram_data        = !ext_ram_oe_n ? ext_rd_val : 32'bz;

  sram_bus_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .sext(sext), .size(size),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ack(ack), .busy(busy),
    .base_ram_data(base_ram_data), .base_ram_addr(base_ram_addr),
    .base_ram_be_n(base_ram_be_n), .base_ram_ce_n(base_ram_ce_n),
    .base_ram_oe_n(base_ram_oe_n), .base_ram_we_n(base_ram_we_n),
    .ext_ram_data(ext_ram_data), .ext_ram_addr(ext_ram_addr),
    .ext_ram_be_n(ext_ram_be_n), .ext_ram_ce_n(ext_ram_ce_n),
    .ext_ram_oe_n(ext_ram_oe_n), .ext_ram_we_n(ext_ram_we_n),
    .uart_rdn(uart_rdn), .uart_wrn(uart_wrn),
    .uart_dataready(uart_dataready), .uart_tbre(uart_tbre), .uart_tsre(uart_tsre)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge of the SETUP cycle
  task automatic issue(input logic w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, input logic sx);
    we = w; size = sz; addr = a; wdata = d; sext = sx; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_val("rst_busy", 32'(busy), 32'h0);
    check_val("rst_ack", 32'(ack), 32'h0);
    check_val("rst_rdata", rdata, 32'h0);
    check_val("rst_base_ce", 32'(base_ram_ce_n), 32'h1);
    check_val("rst_ext_ce", 32'(ext_ram_ce_n), 32'h1);
    check_val("rst_base_be", 32'(base_ram_be_n), 32'hF);
    check_val("rst_strobes", 32'({base_ram_oe_n, base_ram_we_n, ext_ram_oe_n, ext_ram_we_n}), 32'hF);
    check_val("rst_uart", 32'({uart_rdn, uart_wrn}), 32'h3);
    check_val("rst_addr", 32'(base_ram_addr), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Word write to base bank
    issue(1'b1, SZ_WORD, 32'h0000_0010, 32'hDEADBEEF, 1'b0);
    check_val("ww_busy", 32'(busy), 32'h1);
    check_val("ww_base_ce", 32'(base_ram_ce_n), 32'h0);
    check_val("ww_ext_ce", 32'(ext_ram_ce_n), 32'h1);
    check_val("ww_addr", 32'(base_ram_addr), 32'h4);
    check_val("ww_be", 32'(base_ram_be_n), 32'h0);
    check_val("ww_we_setup", 32'(base_ram_we_n), 32'h1);
    check_val("ww_data", base_ram_data, 32'hDEADBEEF);
    @(negedge clk);
    check_val("ww_we_acc1", 32'(base_ram_we_n), 32'h0);
    @(negedge clk);
    check_val("ww_we_acc2", 32'(base_ram_we_n), 32'h0);
    check_val("ww_ack_early", 32'(ack), 32'h0);
    @(negedge clk);
    check_val("ww_ack", 32'(ack), 32'h1);
    check_val("ww_we_done", 32'(base_ram_we_n), 32'h1);
    check_val("ww_ce_done", 32'(base_ram_ce_n), 32'h0);
    @(negedge clk);
    check_val("ww_ack_idle", 32'(ack), 32'h0);
    check_val("ww_busy_idle", 32'(busy), 32'h0);
    check_val("ww_ce_idle", 32'(base_ram_ce_n), 32'h1);
    $display("txn word write 0x00000010 <= 0xDEADBEEF");

    // Byte read from ext bank, sign- and zero-extended
    ext_rd_val = 32'h8011_2233;
    issue(1'b0, SZ_BYTE, 32'h0040_0003, 32'h0, 1'b1);
    check_val("br_ext_ce", 32'(ext_ram_ce_n), 32'h0);
    check_val("br_base_ce", 32'(base_ram_ce_n), 32'h1);
    check_val("br_ext_be", 32'(ext_ram_be_n), 32'h7);
    check_val("br_ext_oe", 32'(ext_ram_oe_n), 32'h0);
    check_val("br_base_be", 32'(base_ram_be_n), 32'hF);
    repeat (3) @(negedge clk);
    check_val("br_ack", 32'(ack), 32'h1);
    check_val("br_sext", rdata, 32'hFFFF_FF80);
    @(negedge clk);
    $display("txn byte read 0x00400003 sext=1");
    issue(1'b0, SZ_BYTE, 32'h0040_0003, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    check_val("br_zext", rdata, 32'h0000_0080);
    @(negedge clk);
    $display("txn byte read 0x00400003 sext=0");

    // Half write to upper lanes
    issue(1'b1, SZ_HALF, 32'h0000_0002, 32'h0000_1234, 1'b0);
    check_val("hw_be", 32'(base_ram_be_n), 32'h3);
    check_val("hw_lanes", 32'(base_ram_data[31:16]), 32'h1234);
    @(negedge clk);
    check_val("hw_we", 32'(base_ram_we_n), 32'h0);
    repeat (2) @(negedge clk);
    check_val("hw_ack", 32'(ack), 32'h1);
    @(negedge clk);
    $display("txn half write 0x00000002 <= 0x1234");

    // Misaligned half read: addr[0] ignored, upper lanes, sign-extended
    issue(1'b0, SZ_HALF, 32'h0040_0003, 32'h0, 1'b1);
    check_val("hr_be", 32'(ext_ram_be_n), 32'h3);
    repeat (3) @(negedge clk);
    check_val("hr_data", rdata, 32'hFFFF_8011);
    @(negedge clk);
    $display("txn half read 0x00400003 sext=1");

    // Byte write replicated across lanes
    issue(1'b1, SZ_BYTE, 32'h0000_0001, 32'h0000_00A5, 1'b0);
    check_val("bw_be", 32'(base_ram_be_n), 32'hD);
    check_val("bw_data", base_ram_data, 32'hA5A5_A5A5);
    repeat (4) @(negedge clk);
    $display("txn byte write 0x00000001 <= 0xA5");

    // Word read with misaligned low bits ignored
    base_rd_val = 32'hCAFE_F00D;
    issue(1'b0, SZ_WORD, 32'h0000_000B, 32'h0, 1'b0);
    check_val("wr_addr", 32'(base_ram_addr), 32'h2);
    check_val("wr_be", 32'(base_ram_be_n), 32'h0);
    check_val("wr_oe", 32'(base_ram_oe_n), 32'h0);
    repeat (3) @(negedge clk);
    check_val("wr_ack", 32'(ack), 32'h1);
    check_val("wr_data", rdata, 32'hCAFE_F00D);
    @(negedge clk);
    $display("txn word read 0x0000000B");

    // Reset abort during ACCESS while req is held high
    we = 1'b1; size = SZ_WORD; addr = 32'h0000_0010; wdata = 32'h1111_2222; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    addr = 32'h0000_0100;
    @(negedge clk);
    check_val("ra_we_acc", 32'(base_ram_we_n), 32'h0);
    check_val("ra_addr_held", 32'(base_ram_addr), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    check_val("ra_we_rst", 32'(base_ram_we_n), 32'h1);
    check_val("ra_ce_rst", 32'(base_ram_ce_n), 32'h1);
    check_val("ra_busy_rst", 32'(busy), 32'h0);
    check_val("ra_rdata_rst", rdata, 32'h0);
    req = 1'b0;
    @(negedge clk);
    check_val("ra_ack_rst", 32'(ack), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("ra_ack_after", 32'(ack), 32'h0);
    check_val("ra_busy_after", 32'(busy), 32'h0);
    $display("txn word write aborted by reset");
    base_rd_val = 32'h0BAD_F00D;
    issue(1'b0, SZ_WORD, 32'h0000_0008, 32'h0, 1'b0);
    check_val("ra_next_busy", 32'(busy), 32'h1);
    check_val("ra_next_addr", 32'(base_ram_addr), 32'h2);
    repeat (3) @(negedge clk);
    check_val("ra_next_ack", 32'(ack), 32'h1);
    check_val("ra_next_data", rdata, 32'h0BAD_F00D);
    @(negedge clk);
    $display("txn word read 0x00000008 after reset");

`ifdef SRAM_BUS_UART_EN
    // UART data write stalls in SETUP until transmitter is ready
    uart_tbre = 1'b0; uart_tsre = 1'b1;
    issue(1'b1, SZ_WORD, 32'h2000_0000, 32'h0000_0055, 1'b0);
    check_val("uw_data", 32'(base_ram_data[7:0]), 32'h55);
    check_val("uw_ce", 32'(base_ram_ce_n), 32'h1);
    for (int i = 0; i < 5; i++) begin
      check_val("uw_stall_wrn", 32'(uart_wrn), 32'h1);
      check_val("uw_stall_busy", 32'(busy), 32'h1);
      @(negedge clk);
    end
    uart_tbre = 1'b1;
    @(negedge clk);
    check_val("uw_wrn1", 32'(uart_wrn), 32'h0);
    @(negedge clk);
    check_val("uw_wrn2", 32'(uart_wrn), 32'h0);
    @(negedge clk);
    check_val("uw_ack", 32'(ack), 32'h1);
    check_val("uw_wrn_done", 32'(uart_wrn), 32'h1);
    @(negedge clk);
    $display("txn uart data write 0x55");

    uart_dataready = 1'b1; uart_tbre = 1'b0;
    issue(1'b0, SZ_WORD, 32'h2000_0004, 32'h0, 1'b0);
    @(negedge clk);
    check_val("us_rdn", 32'(uart_rdn), 32'h1);
    repeat (2) @(negedge clk);
    check_val("us_ack", 32'(ack), 32'h1);
    check_val("us_data", rdata, 32'h0000_0002);
    @(negedge clk);
    uart_tbre = 1'b1;
    $display("txn uart status read");

    uart_rx_val = 8'h3C;
    issue(1'b0, SZ_WORD, 32'h2000_0000, 32'h0, 1'b0);
    @(negedge clk);
    check_val("ur_rdn1", 32'(uart_rdn), 32'h0);
    @(negedge clk);
    check_val("ur_rdn2", 32'(uart_rdn), 32'h0);
    @(negedge clk);
    check_val("ur_ack", 32'(ack), 32'h1);
    check_val("ur_data", rdata, 32'h0000_003C);
    @(negedge clk);
    $display("txn uart data read");
`else
    // Without UART decode the UART-space address lands in base RAM
    issue(1'b1, SZ_WORD, 32'h2000_0010, 32'h0000_0011, 1'b0);
    check_val("nu_ce", 32'(base_ram_ce_n), 32'h0);
    check_val("nu_addr", 32'(base_ram_addr), 32'h4);
    @(negedge clk);
    check_val("nu_we", 32'(base_ram_we_n), 32'h0);
    check_val("nu_uart", 32'({uart_rdn, uart_wrn}), 32'h3);
    repeat (2) @(negedge clk);
    check_val("nu_ack", 32'(ack), 32'h1);
    @(negedge clk);
    $display("txn word write 0x20000010 to base RAM");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
